// File: rtl/tsa_pkg.sv
// -----------------------------------------------------------------------------
// tsa_pkg
// Shared definitions for timer_share_arbiter:
//   - default sizing (requester count, tick-count width, divider width)
//   - FSM state encoding
//   - onehot() and rr_pick() helpers used by the arbiter
// -----------------------------------------------------------------------------
package tsa_pkg;

  localparam int TSA_NREQ  = 4;
  localparam int TSA_CNT_W = 16;
  localparam int TSA_DIV_W = 26;
  localparam int TSA_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tsa_state_e;

  // One-hot vector with bit idx set.
  function automatic logic [TSA_NREQ-1:0] onehot(input logic [TSA_IDX_W-1:0] idx);
    logic [TSA_NREQ-1:0] vec;
    vec      = {TSA_NREQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin pick: first requester at or after ptr (wrapping).
  // Scans from the farthest offset down so the nearest one wins last.
  // Result is only meaningful when reqs != 0.
  function automatic logic [TSA_IDX_W-1:0] rr_pick(input logic [TSA_NREQ-1:0]  reqs,
                                                   input logic [TSA_IDX_W-1:0] ptr);
    logic [TSA_IDX_W-1:0] idx;
    logic [TSA_IDX_W-1:0] pick;
    pick = ptr;
    for (int k = TSA_NREQ - 1; k >= 0; k--) begin
      idx = ptr + k[TSA_IDX_W-1:0];
      if (reqs[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tsa_tick_div.sv
// -----------------------------------------------------------------------------
// tsa_tick_div
// Tick divider owned by timer_share_arbiter. Counts clk10 cycles while en is
// high and emits a one-cycle tick when the count reaches div-1, then wraps.
// A div of zero behaves as one (tick every enabled cycle).
// Ports:
//   clk10  in   system clock
//   reset  in   asynchronous active-high reset
//   clr    in   synchronous clear of the count (has priority over en)
//   en     in   count enable
//   div    in   divider period in clk10 cycles
//   tick   out  combinational wrap pulse (en && count == div-1)
// -----------------------------------------------------------------------------
module tsa_tick_div
  import tsa_pkg::*;
#(
  parameter int DIV_W = TSA_DIV_W
) (
  input  logic             clk10,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_eff_s;
  logic [DIV_W-1:0] last_s;

  // Effective period (zero promoted to one) and terminal count.
  always_comb begin
    if (div == {DIV_W{1'b0}}) begin
      div_eff_s = {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      div_eff_s = div;
    end
    last_s = div_eff_s - {{(DIV_W-1){1'b0}}, 1'b1};
  end

  assign tick = en && (cnt_r == last_s);

  // Divider counter: clear, count, wrap at terminal count.
  always_ff @(posedge clk10 or posedge reset) begin
    if (reset) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      if (cnt_r == last_s) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/timer_share_arbiter.sv
// -----------------------------------------------------------------------------
// timer_share_arbiter
// Shares one tick timer among NREQ (=4) requesters with round-robin
// arbitration. The winner gets a one-shot delay of tick_count[winner] ticks,
// each tick being divider_value clk10 cycles (0 treated as 1). Count and
// divider are latched at grant time.
// Optional build macro TSA_ABORT_EN: when defined, dropping req[winner] during
// RUN returns to IDLE next cycle without a done pulse (pointer still advances).
// Ports:
//   clk10          in   system clock
//   reset          in   asynchronous active-high reset
//   req            in   per-requester level request
//   tick_count     in   requester i count at [i*CNT_W +: CNT_W]
//   divider_value  in   tick period in clk10 cycles
//   gnt            out  one-hot, high while the timer runs for that requester
//   done           out  one-hot, one-cycle pulse when the delay expires
//   busy           out  high in any state other than IDLE
//   tick_out       out  one-cycle pulse on each divider wrap during RUN
// -----------------------------------------------------------------------------
module timer_share_arbiter
  import tsa_pkg::*;
#(
  parameter int NREQ  = TSA_NREQ,
  parameter int CNT_W = TSA_CNT_W,
  parameter int DIV_W = TSA_DIV_W
) (
  input  logic                  clk10,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] tick_count,
  input  logic [DIV_W-1:0]      divider_value,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  tick_out
);

  tsa_state_e           state_r;
  tsa_state_e           state_nxt_s;
  logic [TSA_IDX_W-1:0] win_r;
  logic [TSA_IDX_W-1:0] ptr_r;
  logic [TSA_IDX_W-1:0] pick_s;
  logic [CNT_W-1:0]     pick_count_s;
  logic [DIV_W-1:0]     div_q_r;
  logic [CNT_W-1:0]     remaining_r;
  logic                 any_req_s;
  logic                 tick_s;
  logic                 abort_s;
  logic                 last_tick_s;

  assign any_req_s    = (req != {NREQ{1'b0}});
  assign pick_s       = rr_pick(req, ptr_r);
  assign pick_count_s = tick_count[pick_s*CNT_W +: CNT_W];
  assign last_tick_s  = tick_s && (remaining_r == {{(CNT_W-1){1'b0}}, 1'b1});

`ifdef TSA_ABORT_EN
  assign abort_s = (state_r == ST_RUN) && !req[win_r];
`else
  assign abort_s = 1'b0;
`endif

  tsa_tick_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk10 (clk10),
    .reset (reset),
    .clr   (state_r != ST_RUN),
    .en    (state_r == ST_RUN),
    .div   (div_q_r),
    .tick  (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk10 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          // A zero count skips RUN entirely: done without ever granting.
          if (pick_count_s == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (last_tick_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping: latch winner/settings, count down ticks, advance pointer.
  always_ff @(posedge clk10 or posedge reset) begin
    if (reset) begin
      win_r       <= {TSA_IDX_W{1'b0}};
      ptr_r       <= {TSA_IDX_W{1'b0}};
      div_q_r     <= {DIV_W{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            win_r       <= pick_s;
            div_q_r     <= divider_value;
            remaining_r <= pick_count_s;
          end else begin
            win_r       <= win_r;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            ptr_r <= win_r + 2'd1;
          end else if (tick_s) begin
            remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            remaining_r <= remaining_r;
          end
        end
        ST_DONE: begin
          ptr_r <= win_r + 2'd1;
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  // Output decode from registered state.
  always_comb begin
    gnt      = {NREQ{1'b0}};
    done     = {NREQ{1'b0}};
    busy     = (state_r != ST_IDLE);
    tick_out = tick_s;
    case (state_r)
      ST_RUN:  gnt  = onehot(win_r);
      ST_DONE: done = onehot(win_r);
      default: begin
        gnt  = {NREQ{1'b0}};
        done = {NREQ{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Scoreboard bench for timer_share_arbiter: a transaction-level model predicts
// grant start, grant length, tick count and done timing; a negedge monitor
// compares whatever the DUT presents against the queued expectations.
module tb_timer_share_arbiter;

  logic        clk10 = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] tick_count;
  logic [25:0] divider_value;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        tick_out;

  timer_share_arbiter dut (
    .clk10         (clk10),
    .reset         (reset),
    .req           (req),
    .tick_count    (tick_count),
    .divider_value (divider_value),
    .gnt           (gnt),
    .done          (done),
    .busy          (busy),
    .tick_out      (tick_out)
  );

  always #5 clk10 = ~clk10;

  typedef struct { int w; int cyc; } ev_t;
  typedef struct { int len; int ticks; } end_t;

  ev_t  gq[$];
  ev_t  dq[$];
  end_t eq[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int rst_epoch = 0;
  bit auto_drop = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a timer transaction starting at grant cycle c with count
  // N and period d occupies cycles c+1..c+N*d, done at c+N*d+1, and the next
  // request can be taken at c+N*d+2.
  bit m_active = 1'b0;
  int m_win, m_t0, m_end, m_d, m_n;
  int m_ptr  = 0;
  int m_free = 0;

  always @(posedge clk10) begin
    bit ab;
    int w;
    int idx;
    ab = 1'b0;
    w  = -1;
    if (reset) begin
      gq.delete(); dq.delete(); eq.delete();
      m_active = 1'b0;
      m_ptr    = 0;
      m_free   = cyc + 1;
      rst_epoch++;
    end else if (m_active) begin
`ifdef TSA_ABORT_EN
      ab = !req[m_win];
`endif
      if (ab) begin
        eq.push_back(end_t'{cyc - m_t0, (cyc - m_t0) / m_d});
        m_active = 1'b0;
        m_free   = cyc + 1;
        m_ptr    = (m_win + 1) % 4;
      end else if (cyc == m_end) begin
        eq.push_back(end_t'{m_n * m_d, m_n});
        dq.push_back(ev_t'{m_win, cyc + 1});
        m_active = 1'b0;
        m_free   = cyc + 2;
        m_ptr    = (m_win + 1) % 4;
      end
    end else if (cyc >= m_free && req != 4'd0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && req[idx]) w = idx;
      end
      m_win = w;
      m_n   = int'(tick_count[w*16 +: 16]);
      m_d   = (divider_value == 26'd0) ? 1 : int'(divider_value);
      if (m_n == 0) begin
        dq.push_back(ev_t'{w, cyc + 1});
        m_free = cyc + 2;
        m_ptr  = (w + 1) % 4;
      end else begin
        gq.push_back(ev_t'{w, cyc + 1});
        m_active = 1'b1;
        m_t0     = cyc;
        m_end    = cyc + m_n * m_d;
      end
    end
    cyc++;
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  logic [3:0] prev_gnt = 4'd0;
  logic [3:0] cur_gnt  = 4'd0;
  int glen = 0;
  int tcnt = 0;
  int seen_epoch = 0;

  always @(negedge clk10) begin
    ev_t  e;
    end_t x;
    if (seen_epoch != rst_epoch) begin
      seen_epoch = rst_epoch;
      prev_gnt   = 4'd0;
      glen       = 0;
      tcnt       = 0;
    end
    chk("busy", busy, (gnt != 4'd0) || (done != 4'd0));
    if (gnt != 4'd0 && prev_gnt == 4'd0) begin
      if (gq.size() == 0) chk("unexpected_gnt", gnt, 0);
      else begin
        e = gq.pop_front();
        chk("gnt_who", gnt, 1 << e.w);
        chk("gnt_cycle", cyc, e.cyc);
      end
      cur_gnt = gnt;
      glen    = 1;
      tcnt    = tick_out ? 1 : 0;
    end else if (gnt != 4'd0) begin
      chk("gnt_stable", gnt, cur_gnt);
      glen++;
      if (tick_out) tcnt++;
    end else begin
      chk("tick_outside_run", tick_out, 0);
    end
    if (gnt == 4'd0 && prev_gnt != 4'd0) begin
      if (eq.size() == 0) chk("unexpected_gnt_end", glen, -1);
      else begin
        x = eq.pop_front();
        chk("gnt_len", glen, x.len);
        chk("tick_count", tcnt, x.ticks);
      end
    end
    if (done != 4'd0) begin
      if (dq.size() == 0) chk("unexpected_done", done, 0);
      else begin
        e = dq.pop_front();
        chk("done_who", done, 1 << e.w);
        chk("done_cycle", cyc, e.cyc);
      end
    end
    prev_gnt = gnt;
  end

  task automatic step();
    @(negedge clk10);
    if (auto_drop) req = req & ~done;
  endtask

  task automatic set_cnt(input int i, input int v);
    tick_count[i*16 +: 16] = v[15:0];
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    step();
    while (!(busy == 1'b0 && req == 4'd0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      $display("FAIL wait_idle_timeout: busy=%0b req=%b after %0d cycles", busy, req, n);
    end
  endtask

  task automatic wait_gnt(input int i, input int budget);
    int n;
    n = 0;
    while (!gnt[i] && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      $display("FAIL wait_gnt_timeout: requester %0d not granted in %0d cycles", i, n);
    end
  endtask

  initial begin
    int r;
    reset = 1'b1; req = 4'd0; tick_count = 64'd0; divider_value = 26'd0;
    repeat (3) @(negedge clk10);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick_out, 0);
    reset = 1'b0;
    step();

    // Basic timing: div 4, count 3.
    set_cnt(0, 3); divider_value = 26'd4; req = 4'b0001;
    wait_idle(100);

    // Round robin with all requests held.
    for (int i = 0; i < 4; i++) set_cnt(i, 2);
    divider_value = 26'd1; auto_drop = 1'b0; req = 4'b1111;
    repeat (24) step();
    auto_drop = 1'b1; req = 4'd0;
    wait_idle(100);

    // Zero count: done without grant.
    set_cnt(2, 0); req = 4'b0100;
    wait_idle(50);

    // Zero divider: tick every RUN cycle.
    set_cnt(1, 5); divider_value = 26'd0; req = 4'b0010;
    wait_idle(50);

    // Drop the winner's request mid-RUN while requester 2 waits.
    set_cnt(1, 5); set_cnt(2, 1); divider_value = 26'd2; req = 4'b0010;
    wait_gnt(1, 20);
    repeat (2) step();
    req = 4'b0100;
    wait_idle(100);

    // Randomized traffic.
    for (int i = 0; i < 4; i++) set_cnt(i, $urandom_range(0, 3));
    divider_value = 26'($urandom_range(0, 3));
    for (int t = 0; t < 600; t++) begin
      step();
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) req[r] = 1'b1;
      if ($urandom_range(0, 19) == 0) req[$urandom_range(0, 3)] = 1'b0;
      if ($urandom_range(0, 9) == 0) set_cnt($urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) divider_value = 26'($urandom_range(0, 3));
    end
    req = 4'd0;
    wait_idle(200);

    // Asynchronous reset mid-RUN, then pointer restarts at requester 0.
    set_cnt(0, 5); divider_value = 26'd3; req = 4'b0010;
    step(); req = 4'b0001;
    wait_gnt(0, 30);
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tick", tick_out, 0);
    @(posedge clk10);
    @(negedge clk10);
    reset = 1'b0;
    set_cnt(3, 2); divider_value = 26'd1; req = 4'b1000;
    wait_idle(50);

    repeat (3) step();
    chk("pending_expectations", gq.size() + dq.size() + eq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
